sequential_divider: RTL

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sequential_divider.sv
// Sequential restoring divider: unsigned WIDTH-bit operands, one quotient bit per clock.
//
// Ports
//   clk         : clock; all state changes on the rising edge
//   reset       : asynchronous, active-high; aborts any operation and clears all state
//   start       : begin a division (accepted only in IDLE or DONE)
//   dividend    : unsigned dividend, sampled with start
//   divisor     : unsigned divisor, sampled with start
//   quotient    : registered quotient of the last completed operation
//   remainder   : registered remainder of the last completed operation
//   busy        : high while iterating (CALC)
//   done        : one-cycle pulse; quotient/remainder/div_by_zero freshly valid
//   div_by_zero : registered flag, set when the last completed operation had divisor 0
module sequential_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;    // latched divisor
  logic [CntW-1:0]  cnt_q, cnt_d;    // steps still to perform
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  // One restoring step. The shifted remainder needs WIDTH+1 bits; one more bit
  // carries the sign of the trial subtraction.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             qbit;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic             unused_trial;

  always_comb begin
    shifted      = {rem_q, dvd_q[WIDTH-1]};
    trial        = {1'b0, shifted} - {2'b00, dvs_q};
    qbit         = ~trial[WIDTH+1];
    // A kept trial result is below the divisor, so its low WIDTH bits are exact.
    step_rem     = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_dvd     = {dvd_q[WIDTH-2:0], qbit};
    unused_trial = trial[WIDTH];
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          rem_d = '0;
          if (divisor == '0) begin
            // Divide by zero completes on the start edge without iterating.
            state_d = DONE;
            cnt_d   = '0;
            quo_d   = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CntW'(WIDTH);
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        dvd_d = step_dvd;
        rem_d = step_rem;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = DONE;
          quo_d   = step_dvd;
          remo_d  = step_rem;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);

endmodule
